// File: rtl/p_hardisc.sv
// Shared hardisc definitions: scrubber FSM encoding, default scrub period and
// the column map of the (39,32) SECDED code protecting the register file.
package p_hardisc;

    localparam int SCRB_PERIOD_DEF = 64;

    typedef enum logic [1:0] {
        SCRB_IDLE,
        SCRB_READ,
        SCRB_CHECK,
        SCRB_FIX
    } scrub_fsm;

    // Data bit j sits at the j-th non-power-of-two Hamming position; bit 6 is set
    // whenever that position has even weight, so every data column is odd-weight.
    function automatic logic [6:0] secded_col(input int j);
        logic [5:0] pos;
        int         cnt;
        pos = '0;
        cnt = 0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) pos = 6'(p);
                cnt++;
            end
        end
        return {~(^pos), pos};
    endfunction

endpackage

// File: rtl/secded_analyze.sv
// Classifies a SECDED syndrome as correctable (single flip) or uncorrectable.
module secded_analyze
    import p_hardisc::*;
(
    input  logic [6:0] syn_i,
    output logic       ce_o,
    output logic       uce_o
);

    logic hit;

    // A lone check-bit flip shows up as a one-hot syndrome and leaves the data intact.
    always_comb begin
        hit = $onehot(syn_i);
        for (int j = 0; j < 32; j++) begin
            if (syn_i == secded_col(j)) hit = 1'b1;
        end
        ce_o  = hit;
        uce_o = (syn_i != '0) && !hit;
    end

endmodule

// File: rtl/secded_decode.sv
// Flips the data bit addressed by a single-error SECDED syndrome.
module secded_decode
    import p_hardisc::*;
(
    input  logic [31:0] data_i,
    input  logic [6:0]  syn_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        for (int j = 0; j < 32; j++) begin
            if (syn_i == secded_col(j)) data_o[j] = ~data_i[j];
        end
    end

endmodule

// File: rtl/secded_encode.sv
// SECDED(39,32) checksum generator for one register-file word.
module secded_encode
    import p_hardisc::*;
(
    input  logic [31:0] data_i,
    output logic [6:0]  chs_o
);

    always_comb begin
        chs_o = '0;
        for (int j = 0; j < 32; j++) begin
            if (data_i[j]) chs_o = chs_o ^ secded_col(j);
        end
    end

endmodule

// File: rtl/rf_scrubber.sv
// Register-file scrubber: every PERIOD idle cycles reads one register on the spare
// port, checks its SECDED checksum and writes back single-bit corrections.
module rf_scrubber
    import p_hardisc::*;
#(
    parameter int PERIOD = SCRB_PERIOD_DEF
)(
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_enable_i,
    input  logic        s_wb_we_i,
    input  logic [4:0]  s_wb_add_i,
    output logic        s_rd_req_o,
    output logic [4:0]  s_rd_add_o,
    input  logic        s_rd_gnt_i,
    input  logic [31:0] s_rd_val_i,
    input  logic [6:0]  s_rd_chs_i,
    output logic        s_fix_we_o,
    output logic [4:0]  s_fix_add_o,
    output logic [31:0] s_fix_val_o,
    output logic        s_uce_o,
    output logic [7:0]  s_ce_cnt_o,
    output logic        s_busy_o
);

    localparam logic [15:0] TIMER_LAST = 16'(PERIOD - 1);

    scrub_fsm    state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] fix_q, fix_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [6:0]  enc_chs, syn;
    logic [31:0] dec_val;
    logic        syn_ce, syn_uce;
    logic        wb_hit;
    logic [4:0]  ptr_next;
    logic        rd_req, fix_we, uce;

    secded_encode  u_enc (.data_i(s_rd_val_i), .chs_o(enc_chs));
    secded_analyze u_ana (.syn_i(syn), .ce_o(syn_ce), .uce_o(syn_uce));
    secded_decode  u_dec (.data_i(s_rd_val_i), .syn_i(syn), .data_o(dec_val));

    assign syn      = enc_chs ^ s_rd_chs_i;
    assign wb_hit   = s_wb_we_i && (s_wb_add_i == ptr_q);
    assign ptr_next = (ptr_q == 5'd31) ? 5'd1 : ptr_q + 5'd1;

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q <= SCRB_IDLE;
            timer_q <= '0;
            ptr_q   <= 5'd1;
            fix_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            fix_q   <= fix_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        fix_d   = fix_q;
        cnt_d   = cnt_q;
        rd_req  = 1'b0;
        fix_we  = 1'b0;
        uce     = 1'b0;
        case (state_q)
            SCRB_IDLE: begin
                if (!s_enable_i) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = SCRB_READ;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            SCRB_READ: begin
                rd_req = 1'b1;
                if (s_rd_gnt_i)       state_d = SCRB_CHECK;
                else if (!s_enable_i) state_d = SCRB_IDLE;
            end
            // A WB write to the scrubbed register makes the read result stale.
            SCRB_CHECK: begin
                state_d = SCRB_IDLE;
                if (wb_hit) begin
                    ptr_d = ptr_next;
                end else if (syn_ce) begin
                    fix_d   = dec_val;
                    state_d = SCRB_FIX;
                end else begin
                    uce   = syn_uce;
                    ptr_d = ptr_next;
                end
            end
            SCRB_FIX: begin
                fix_we = !s_wb_we_i;
                if (!s_wb_we_i) begin
                    ptr_d   = ptr_next;
                    state_d = SCRB_IDLE;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else if (wb_hit) begin
                    ptr_d   = ptr_next;
                    state_d = SCRB_IDLE;
                end
            end
            default: state_d = SCRB_IDLE;
        endcase
    end

    // Reset masks the strobes combinationally so a fix pending at reset never writes.
    assign s_rd_req_o  = rd_req && !s_reset_i;
    assign s_fix_we_o  = fix_we && !s_reset_i;
    assign s_uce_o     = uce && !s_reset_i;
    assign s_busy_o    = (state_q != SCRB_IDLE) && !s_reset_i;
    assign s_rd_add_o  = ptr_q;
    assign s_fix_add_o = ptr_q;
    assign s_fix_val_o = fix_q;
    assign s_ce_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rf_scrubber.sv
// Bench for rf_scrubber: randomized scrub steps with injected bit flips and WB
// interference, checked against a transaction-level model of pointer and counter.
module tb_rf_scrubber;

    localparam int PERIOD = 4;

    logic        clk = 1'b0;
    logic        reset, enable, wb_we, gnt;
    logic [4:0]  wb_add;
    logic [31:0] rd_val;
    logic [6:0]  rd_chs;
    logic        rd_req, fix_we, uce, busy;
    logic [4:0]  rd_add, fix_add;
    logic [31:0] fix_val;
    logic [7:0]  ce_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int mptr, mcnt;

    rf_scrubber #(.PERIOD(PERIOD)) dut (
        .s_clk_i(clk), .s_reset_i(reset), .s_enable_i(enable),
        .s_wb_we_i(wb_we), .s_wb_add_i(wb_add),
        .s_rd_req_o(rd_req), .s_rd_add_o(rd_add), .s_rd_gnt_i(gnt),
        .s_rd_val_i(rd_val), .s_rd_chs_i(rd_chs),
        .s_fix_we_o(fix_we), .s_fix_add_o(fix_add), .s_fix_val_o(fix_val),
        .s_uce_o(uce), .s_ce_cnt_o(ce_cnt), .s_busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Checksum from the code definition: check bit i covers data at Hamming positions
    // with bit i set; bit 6 covers data at even-weight positions.
    function automatic logic [6:0] ref_encode(input logic [31:0] d);
        logic [6:0] c;
        int         j;
        c = '0;
        j = 0;
        for (int p = 3; p < 39; p++) begin
            if ($countones(p) != 1) begin
                if (d[j]) begin
                    for (int i = 0; i < 6; i++) if (((p >> i) & 1) == 1) c[i] = ~c[i];
                    if (($countones(p) % 2) == 0) c[6] = ~c[6];
                end
                j++;
            end
        end
        return c;
    endfunction

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_we  = 1'b0;
        wb_add = '0;
        gnt    = 1'b0;
        rd_val = '0;
        rd_chs = '0;
    endtask

    function automatic logic [4:0] other_addr();
        logic [4:0] a;
        a = 5'($urandom_range(0, 31));
        if (a == 5'(mptr)) a = a + 5'd1;
        return a;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            to_neg();
            if (rd_req) begin
                ok = 1'b1;
                break;
            end
            to_pos();
        end
        if (!ok) check("rd_req_timeout", 0, 1);
    endtask

    task automatic expect_req_after(input int n);
        for (int i = 0; i < n; i++) begin
            to_neg();
            check("req_early", rd_req, 0);
            check("busy_idle", busy, 0);
            to_pos();
        end
        to_neg();
        check("req_on_time", rd_req, 1);
        check("req_add", rd_add, mptr);
    endtask

    // kind: 0 clean, 1 data-bit flip (b1), 2 check-bit flip (b1), 3 double flip (b1, b2>=32 is a check bit)
    // wbchk: WB in check cycle 0 none, 1 to ptr, 2 elsewhere; nstall WB cycles to x3 before the final FIX cycle
    task automatic scrub_step(input int kind, input logic [31:0] v, input int b1, input int b2,
                              input int wbchk, input int nstall, input bit drop, input int gdelay);
        bit          ok;
        bit          ce;
        logic [31:0] val;
        logic [6:0]  chs;
        wait_req(ok);
        if (!ok) return;
        check("rd_add", rd_add, mptr);
        check("fix_we_read", fix_we, 0);
        for (int i = 0; i < gdelay; i++) begin
            to_pos();
            to_neg();
            check("rd_req_hold", rd_req, 1);
        end
        to_pos();
        gnt = 1'b1;
        to_pos();
        gnt = 1'b0;
        val = v;
        chs = ref_encode(v);
        case (kind)
            1: val[b1] = ~val[b1];
            2: chs[b1] = ~chs[b1];
            3: begin
                val[b1] = ~val[b1];
                if (b2 < 32) val[b2] = ~val[b2];
                else         chs[b2 - 32] = ~chs[b2 - 32];
            end
            default: ;
        endcase
        rd_val = val;
        rd_chs = chs;
        wb_we  = (wbchk != 0);
        wb_add = (wbchk == 1) ? 5'(mptr) : other_addr();
        to_neg();
        check("uce_check", uce, (kind == 3 && wbchk != 1));
        check("fix_we_check", fix_we, 0);
        check("busy_check", busy, 1);
        ce = (kind == 1 || kind == 2) && (wbchk != 1);
        to_pos();
        idle_inputs();
        if (ce) begin
            for (int i = 0; i < nstall; i++) begin
                wb_we  = 1'b1;
                wb_add = (mptr == 3) ? 5'd4 : 5'd3;
                to_neg();
                check("fix_we_stall", fix_we, 0);
                check("busy_fix", busy, 1);
                to_pos();
            end
            wb_we  = drop;
            wb_add = 5'(mptr);
            to_neg();
            check("fix_we", fix_we, !drop);
            check("rd_req_fix", rd_req, 0);
            if (!drop) begin
                check("fix_add", fix_add, mptr);
                check("fix_val", fix_val, v);
                if (mcnt < 255) mcnt++;
            end
            to_pos();
            wb_we = 1'b0;
        end
        mptr = (mptr == 31) ? 1 : mptr + 1;
        to_neg();
        check("busy_after", busy, 0);
        check("uce_after", uce, 0);
        check("fix_we_after", fix_we, 0);
        check("ptr_after", rd_add, mptr);
        check("ce_cnt", ce_cnt, mcnt);
    endtask

    task automatic random_step();
        int kind, b1, b2, wbchk;
        kind = $urandom_range(0, 3);
        b1   = (kind == 2) ? $urandom_range(0, 6) : $urandom_range(0, 31);
        b2   = $urandom_range(0, 38);
        if (b2 == b1) b2 = 32;
        wbchk = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 3) == 0) ? 2 : 0);
        scrub_step(kind, $urandom, b1, b2, wbchk, $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    endtask

    initial begin
        bit ok;
        reset  = 1'b1;
        enable = 1'b1;
        idle_inputs();
        mptr = 1;
        mcnt = 0;
        repeat (3) to_pos();
        to_neg();
        check("rst_rd_req", rd_req, 0);
        check("rst_fix_we", fix_we, 0);
        check("rst_uce", uce, 0);
        check("rst_busy", busy, 0);
        check("rst_ce_cnt", ce_cnt, 0);
        check("rst_fix_val", fix_val, 0);
        check("rst_rd_add", rd_add, 1);
        check("rst_fix_add", fix_add, 1);
        to_pos();
        reset = 1'b0;
        expect_req_after(PERIOD);

        repeat (4) scrub_step(0, $urandom, 0, 0, 0, 0, 1'b0, 0);
        scrub_step(1, 32'h0000_00A5, 3, 0, 0, 0, 1'b0, 0);
        scrub_step(0, $urandom, 0, 0, 0, 0, 1'b0, 0);
        scrub_step(3, $urandom, 2, 17, 0, 0, 1'b0, 0);
        scrub_step(0, $urandom, 0, 0, 0, 0, 1'b0, 0);
        scrub_step(1, $urandom, 5, 0, 0, 3, 1'b0, 0);

        repeat (100) random_step();

        while (mptr != 9) scrub_step(0, $urandom, 0, 0, 0, 0, 1'b0, 0);
        scrub_step(1, $urandom, 12, 0, 0, 0, 1'b1, 0);

        while (mcnt < 255) scrub_step(1, $urandom, $urandom_range(0, 31), 0, 0, 0, 1'b0, 0);
        scrub_step(2, $urandom, 4, 0, 0, 0, 1'b0, 0);
        scrub_step(1, $urandom, 30, 0, 0, 1, 1'b0, 1);

        // Enable drops while the read is still ungranted.
        wait_req(ok);
        if (ok) begin
            to_pos();
            enable = 1'b0;
            to_neg();
            check("drop_still_read", rd_req, 1);
            to_pos();
            to_neg();
            check("drop_rd_req", rd_req, 0);
            check("drop_busy", busy, 0);
            check("drop_ptr", rd_add, mptr);
            repeat (10) begin
                to_pos();
                to_neg();
                check("disabled_req", rd_req, 0);
            end
            to_pos();
            enable = 1'b1;
            expect_req_after(PERIOD);
            scrub_step(0, $urandom, 0, 0, 0, 0, 1'b0, 0);
        end

        // Reset lands while a correction waits in FIX.
        wait_req(ok);
        if (ok) begin
            to_pos();
            gnt = 1'b1;
            to_pos();
            gnt    = 1'b0;
            rd_val = 32'h1234_5678 ^ 32'h0000_0100;
            rd_chs = ref_encode(32'h1234_5678);
            to_neg();
            check("pre_rst_uce", uce, 0);
            to_pos();
            idle_inputs();
            reset = 1'b1;
            to_neg();
            check("rst_fix_we_mid", fix_we, 0);
            check("rst_busy_mid", busy, 0);
            to_pos();
            to_pos();
            reset = 1'b0;
            mptr  = 1;
            mcnt  = 0;
            to_neg();
            check("rst2_ptr", rd_add, 1);
            check("rst2_ce_cnt", ce_cnt, 0);
            check("rst2_fix_val", fix_val, 0);
            check("rst2_fix_we", fix_we, 0);
            to_pos();
            expect_req_after(PERIOD - 1);
            scrub_step(0, $urandom, 0, 0, 0, 0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
